// File: rtl/tt_input_debounce.sv
// Per-bit pin conditioning: two-flop synchroniser, stability counter and optional edge pulses.
// Optional macro TT_DEBOUNCE_EDGE_EN builds the rise/fall/any_change pulse registers; otherwise they read 0.
module tt_input_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] clean_q, clean_d;

  // The synchroniser runs regardless of ena so the filter sees fresh data on resume.
  always_comb begin
    s1_d = raw_in;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      clean_q <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      clean_q <= clean_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CW-1:0] cnt_q, cnt_d;
      logic          clean_bit_d;

      always_comb begin
        cnt_d       = cnt_q;
        clean_bit_d = clean_q[gi];
        if (ena) begin
          if (s2_q[gi] == clean_q[gi]) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            clean_bit_d = s2_q[gi];
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign clean_d[gi] = clean_bit_d;
    end
  endgenerate

  assign clean_out = clean_q;

`ifdef TT_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             any_q, any_d;

  // clean_d equals clean_q whenever ena is low, so pulses vanish during a freeze.
  always_comb begin
    rise_d = clean_d & ~clean_q;
    fall_d = ~clean_d & clean_q;
    any_d  = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_change = any_q;
`else
  assign rise_pulse = '0;
  assign fall_pulse = '0;
  assign any_change = 1'b0;
`endif

endmodule

// File: doc/tt_input_debounce.md
# tt_input_debounce

Input-conditioning stage between the dedicated input pins and the user logic of the TinyTapeout top level. It synchronises each asynchronous pin (buttons, switches) to `clk` and filters contact bounce. It produces a stable level per bit, plus optional one-cycle rising and falling edge pulses. Downstream combinational logic consumes `clean_out` in place of the raw pins.

## Interface
- `WIDTH`, default 8: number of independent input bits.
- `STABLE_CYCLES`, default 1000: consecutive cycles a synchronised input must differ from `clean_out` before `clean_out` follows it. Legal range 1..65535; 0 is illegal.
- `clk` input 1: system clock, one clock domain.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ena` input 1: filter enable. High means normal operation; low freezes the filter.
- `raw_in` input WIDTH: asynchronous pin levels.
- `clean_out` output WIDTH: debounced level. Reset value 0.
- `rise_pulse` output WIDTH: one-cycle pulse when `clean_out[i]` goes 0→1. Reset value 0.
- `fall_pulse` output WIDTH: one-cycle pulse when `clean_out[i]` goes 1→0. Reset value 0.
- `any_change` output 1: OR of all rise and fall pulses, registered. Reset value 0.

## Operation
- Each bit is independent and has the same logic. There is no cross-bit interaction except `any_change`.
- **Synchroniser:** two flops per bit (`s1`, `s2`), reset to 0. They sample `raw_in` every cycle regardless of `ena`. `s2` is the synchronised level.
- **Counter:** one per bit, width `$clog2(STABLE_CYCLES+1)`, reset to 0. Each edge with `ena`=1 applies the first matching rule:
  - If `s2 == clean_out[i]`: counter ← 0.
  - Else if counter `== STABLE_CYCLES-1`: `clean_out[i]` ← `s2`, counter ← 0.
  - Else: counter ← counter + 1.
  - The counter can never wrap.
- **Glitch rejection:** any return of `s2` to the `clean_out` value before the threshold clears the counter. This means `STABLE_CYCLES` consecutive differing samples are required.
- **Edge pulses:** registered.
  - `rise_pulse[i]` is high for exactly the one cycle following the edge that sets `clean_out[i]` to 1. `fall_pulse[i]` behaves the same for a change to 0.
  - Both pulses are 0 in every other cycle. They are never high together.
  - `any_change` is high in the same cycle as any pulse.
- **`ena`=0:**
  - Counters and `clean_out` hold their values.
  - All pulses and `any_change` are 0.
  - The synchroniser keeps running.
  - When `ena` returns to 1, counting resumes from the held counter value.
- **Reset:** `rst_n` low asynchronously clears all flops. A pin held high through reset therefore produces one `rise_pulse` once it is filtered after release; this is intended behaviour.
- Reset asserted mid-count discards the count. There is no partial state after reset release.

## Timing
- Latency, with `ena`=1: if `raw_in[i]` changes before edge k and stays stable, `s2` updates at edge k+1. `clean_out[i]` and the pulse update at edge k+1+`STABLE_CYCLES`, i.e. `STABLE_CYCLES`+2 edges after the first sampling edge.
- `STABLE_CYCLES`=1 gives a minimum latency of 3 edges; glitches of one sampled cycle still propagate.
- Pulse width is exactly one `clk` cycle.
- Throughput: at most one `clean_out` transition per bit per `STABLE_CYCLES` cycles.
- All outputs are driven directly from flops; there is no combinational path from any input to any output.

## Configuration
- `TT_DEBOUNCE_EDGE_EN` defined: the pulse registers for `rise_pulse`, `fall_pulse` and `any_change` are built as described above.
- Macro undefined: the pulse logic is removed. `rise_pulse`, `fall_pulse` and `any_change` are tied to constant 0. `clean_out` behaviour is unchanged.

## Test plan
Use `WIDTH`=8, `STABLE_CYCLES`=4 and the macro defined unless noted.

1. **Reset:** assert `rst_n`=0 with `raw_in`=8'hFF. All outputs read 0 during reset and on the first edge after release.
2. **Clean rise:** `raw_in[0]` 0→1 before edge k, held. `clean_out[0]`=1 after edge k+5; `rise_pulse[0]` and `any_change` are high for that one cycle only. `fall_pulse` stays 0.
3. **Glitch:** `raw_in[1]` high for 3 cycles, then low. `clean_out[1]` stays 0 and no pulse occurs. Repeat with 4 cycles: `clean_out[1]` rises, then falls 6 edges after `raw_in[1]` returns low, with one `fall_pulse[1]`.
4. **Bounce:** `raw_in[2]` toggles every 2 cycles for 20 cycles, then holds 1. Exactly one `rise_pulse[2]`, 6 edges after the last toggle.
5. **Enable freeze:** start a rise on bit 3 and drop `ena` after 2 counts for 10 cycles. Nothing changes while `ena` is low; `clean_out[3]` rises 2 edges after `ena` returns to 1.
6. **Async reset mid-count, and macro off:**
   - Assert `rst_n` at counter=3 with `raw_in[4]`=1. `clean_out` clears immediately; after release the full 6-edge latency reapplies.
   - Rebuild without `TT_DEBOUNCE_EDGE_EN`: scenario 2 gives the same `clean_out` with all pulses 0.
